axi_burst_master: RTL and testbench
===================================

// Module: axi_burst_master
// PURPOSE
//  Command-driven AXI3/4 master that issues one INCR burst (write or read) at a time.
//  Write data is taken from a valid/ready stream; read data is returned on a valid/ready stream.
//  Sits directly upstream of axi_sram (or any axi_ifc slave) and lets test logic or a DMA engine
//  move bursts of 32-bit words without handling AXI channels itself.
// PARAMETERS
//  AXI_ID   0   value driven on awid/arid for every burst (width = $bits(m.awid))
// PORTS
//  clk        in   1    single clock; all logic on posedge
//  rstn       in   1    asynchronous, active-low reset
//  m          axi_ifc.master  AXI master port; address/data/ID widths inherited from interface
//  cmd_valid  in   1    command present
//  cmd_ready  out  1    command accepted when cmd_valid & cmd_ready
//  cmd_write  in   1    1 = write burst, 0 = read burst
//  cmd_addr   in   32   start byte address, word aligned (bits [1:0] ignored, driven 0 on bus)
//  cmd_len    in   8    beats-1 (0..255), copied to awlen/arlen
//  wr_data    in   32   write beat data
//  wr_valid   in   1    write beat present
//  wr_ready   out  1    write beat consumed
//  rd_data    out  32   read beat data
//  rd_valid   out  1    read beat present
//  rd_ready   in   1    read beat consumed
//  rd_last    out  1    final beat of burst (from internal beat counter)
//  done       out  1    one-cycle pulse: burst complete
//  err        out  1    valid with done: nonzero bresp/rresp seen, or rlast mismatch
// BEHAVIOUR
//  Reset (rstn low, async): state IDLE; cmd_ready, awvalid, arvalid, bready, done, err = 0; beat count = 0.
//   cmd_ready rises on first clk edge after rstn release.
//   Reset mid-burst abandons the burst; no completion is reported.
//  Fixed fields: awsize/arsize = 3'b010, awburst/arburst = INCR, wstrb = 4'hF. Other AXI sideband fields = 0.
//  States:
//   IDLE: cmd_ready=1. On cmd handshake, latch addr/len/write and deassert cmd_ready next cycle.
//     write -> AW with awvalid=1; read -> AR with arvalid=1.
//   AW: hold awvalid/awaddr/awlen stable until awready; then -> W, awvalid=0.
//   W: pass-through (combinational): m.wvalid = wr_valid, wr_ready = m.wready, m.wdata = wr_data.
//     m.wlast = (beat == len). Beat++ on each wvalid&wready.
//     On the last beat: -> B, bready=1.
//   B: on bvalid&bready: bready=0; done=1 next cycle; err = (bresp != 0). Then -> IDLE.
//   AR: hold arvalid until arready; then -> R.
//   R: pass-through: rd_valid = m.rvalid, m.rready = rd_ready, rd_data = m.rdata, rd_last = (beat == len).
//     Beat++ on each rvalid&rready. Any rresp != 0 sets sticky err.
//     m.rlast != (beat == len) on a handshake also sets sticky err.
//     On the last counted beat: done=1 next cycle, -> IDLE.
//  No W beats are driven before the AW handshake; wr_ready=0 outside W; rd_valid=0 outside R.
//  Outside W/R, m.wvalid and m.rready are 0.
//  Latency: cmd handshake -> awvalid/arvalid high on next edge. Final B/R handshake -> done pulse on next edge.
//   cmd_ready=1 on the edge after done.
//  Sticky err clears on each new command accept.
//  len=0: single beat; wlast/rd_last high on the first beat.
//  Addresses increment in the slave; the master never splits bursts.
//   Callers must keep bursts within 4KB.
//  cmd_valid while busy is ignored (held by caller).
// TESTING
//  1. Write addr=0x100, len=3, data 0x11,0x22,0x33,0x44 -> awaddr=0x100, awlen=3;
//     wlast only on 0x44; done=1, err=0.
//  2. Read addr=0x100, len=3 after test 1 -> rd_data 0x11..0x44; rd_last only on 4th beat; done, err=0.
//  3. Read len=0 at 0x104 -> exactly one beat, data 0x22, rd_last=1 on it.
//  4. Random wr_valid gaps and rd_ready stalls (50%), len=15 -> data order preserved, no beat lost or duplicated.
//  5. Slave returns bresp=2'b10 -> done with err=1; next cmd clean -> err=0.
//  6. Deassert rstn after 2 of 8 write beats -> all valids 0 immediately, no done.
//     cmd_ready=1 one edge after release.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// AXI3/4 channel bundle shared by burst masters and slaves.
// Address, data and ID widths are parameters; all other field widths follow AXI4.
interface axi_ifc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Command-driven AXI master: one INCR burst of 32-bit words at a time, write data
// streamed in and read data streamed out through valid/ready pass-throughs.
module axi_burst_master #(
  parameter int AXI_ID = 0
) (
  input  logic        clk,
  input  logic        rstn,
  axi_ifc.master      m,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]  state;
  logic        awvalid_q;
  logic        arvalid_q;
  logic        bready_q;
  logic        done_q;
  logic        err_q;
  logic [7:0]  beat;
  logic [7:0]  len_q;
  logic [31:0] addr_q;

  logic        in_w;
  logic        in_r;
  logic        cmd_hs;
  logic        w_hs;
  logic        r_hs;
  logic        beat_last;

  assign in_w      = (state == S_W);
  assign in_r      = (state == S_R);
  assign cmd_hs    = (state == S_IDLE) && cmd_valid && cmd_ready;
  assign beat_last = (beat == len_q);
  assign w_hs      = in_w && wr_valid && m.wready;
  assign r_hs      = in_r && m.rvalid && rd_ready;

  // Command stage: address and length are data, captured on accept without reset
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      addr_q <= cmd_addr & ~32'h3;
      len_q  <= cmd_len;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      beat      <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_hs) begin
            cmd_ready <= 1'b0;
            err_q     <= 1'b0;
            beat      <= 8'd0;
            if (cmd_write) begin
              state     <= S_AW;
              awvalid_q <= 1'b1;
            end else begin
              state     <= S_AR;
              arvalid_q <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_AW: begin
          if (m.awready) begin
            awvalid_q <= 1'b0;
            state     <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            beat <= beat + 8'd1;
            if (beat_last) begin
              state    <= S_B;
              bready_q <= 1'b1;
            end
          end
        end
        S_B: begin
          if (m.bvalid && bready_q) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= (m.bresp != 2'b00);
            state    <= S_DONE;
          end
        end
        S_AR: begin
          if (m.arready) begin
            arvalid_q <= 1'b0;
            state     <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            beat <= beat + 8'd1;
            // Slave's rlast must agree with our own beat count, otherwise flag it
            if ((m.rresp != 2'b00) || (m.rlast != beat_last)) begin
              err_q <= 1'b1;
            end
            if (beat_last) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done = done_q;
  assign err  = err_q;

  // Write address channel
  assign m.awid    = $bits(m.awid)'(AXI_ID);
  assign m.awaddr  = addr_q;
  assign m.awlen   = len_q;
  assign m.awsize  = 3'b010;
  assign m.awburst = 2'b01;
  assign m.awlock  = 1'b0;
  assign m.awcache = 4'd0;
  assign m.awprot  = 3'd0;
  assign m.awqos   = 4'd0;
  assign m.awvalid = awvalid_q;

  // Write data channel is a pass-through of the beat stream, gated to the W state
  assign m.wdata  = wr_data;
  assign m.wstrb  = 4'hF;
  assign m.wlast  = in_w && beat_last;
  assign m.wvalid = in_w && wr_valid;
  assign wr_ready = in_w && m.wready;

  assign m.bready = bready_q;

  // Read address channel
  assign m.arid    = $bits(m.arid)'(AXI_ID);
  assign m.araddr  = addr_q;
  assign m.arlen   = len_q;
  assign m.arsize  = 3'b010;
  assign m.arburst = 2'b01;
  assign m.arlock  = 1'b0;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.arqos   = 4'd0;
  assign m.arvalid = arvalid_q;

  // Read data channel pass-through, gated to the R state
  assign rd_data  = m.rdata;
  assign rd_valid = in_r && m.rvalid;
  assign rd_last  = in_r && beat_last;
  assign m.rready = in_r && rd_ready;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: randomized AXI slave plus a word-addressed reference memory
// filled from the commanded write data; read bursts are checked against it.
module tb_axi_burst_master;
  localparam int TB_ID = 5;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        rd_last;
  logic        done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] smem [int];
  logic [31:0] cur_addr = '0;
  logic [7:0]  cur_len = '0;
  logic [1:0]  inj_bresp = '0;
  logic [1:0]  inj_rresp = '0;
  bit          bad_rlast = 1'b0;

  always #5 clk = ~clk;

  axi_ifc #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

  axi_burst_master #(.AXI_ID(TB_ID)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m         (bus),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Randomized slave: samples handshakes mid-cycle, updates its drives just after the edge
  initial begin : slave
    bit aw_ok, b_pend, r_act, hs_r;
    int w_base, w_len, w_idx, r_base, r_len, r_idx;
    aw_ok = 0; b_pend = 0; r_act = 0; hs_r = 0;
    w_base = 0; w_len = 0; w_idx = 0; r_base = 0; r_len = 0; r_idx = 0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bid = '0; bus.bresp = '0; bus.bvalid = 1'b0;
    bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    forever begin
      @(negedge clk);
      hs_r = 0;
      if (!rstn) begin
        aw_ok = 0; b_pend = 0; r_act = 0;
      end else begin
        if (bus.wvalid && bus.wready) begin
          chk("w_after_aw", 32'(aw_ok), 32'd1);
          chk("wstrb", 32'(bus.wstrb), 32'hF);
          chk("wlast", 32'(bus.wlast), 32'(w_idx == w_len));
          chk("wdata", bus.wdata, ref_mem[w_base + w_idx]);
          smem[w_base + w_idx] = bus.wdata;
          if (w_idx == w_len) begin
            b_pend = 1; aw_ok = 0;
          end
          w_idx++;
        end
        if (bus.awvalid && bus.awready) begin
          chk("awaddr", bus.awaddr, cur_addr & ~32'h3);
          chk("awlen", 32'(bus.awlen), 32'(cur_len));
          chk("awsize", 32'(bus.awsize), 32'd2);
          chk("awburst", 32'(bus.awburst), 32'd1);
          chk("awid", 32'(bus.awid), 32'(TB_ID));
          aw_ok = 1; w_base = int'(bus.awaddr >> 2); w_len = int'(bus.awlen); w_idx = 0;
        end
        if (bus.bvalid && bus.bready) b_pend = 0;
        if (bus.rvalid && bus.rready) begin
          hs_r = 1;
          r_idx++;
          if (r_idx > r_len) r_act = 0;
        end
        if (bus.arvalid && bus.arready) begin
          chk("araddr", bus.araddr, cur_addr & ~32'h3);
          chk("arlen", 32'(bus.arlen), 32'(cur_len));
          chk("arsize", 32'(bus.arsize), 32'd2);
          chk("arburst", 32'(bus.arburst), 32'd1);
          chk("arid", 32'(bus.arid), 32'(TB_ID));
          r_act = 1; r_base = int'(bus.araddr >> 2); r_len = int'(bus.arlen); r_idx = 0;
        end
      end
      @(posedge clk); #1;
      bus.awready = 1'($urandom_range(0, 1));
      bus.wready  = 1'($urandom_range(0, 1));
      bus.arready = 1'($urandom_range(0, 1));
      bus.bvalid  = b_pend && (bus.bvalid || ($urandom_range(0, 1) == 1));
      bus.bresp   = inj_bresp;
      bus.bid     = 4'(TB_ID);
      bus.rvalid  = r_act && ((bus.rvalid && !hs_r) || ($urandom_range(0, 2) != 0));
      bus.rdata   = smem.exists(r_base + r_idx) ? smem[r_base + r_idx] : 32'hBAD0_BAD0;
      bus.rlast   = r_act && ((r_idx == r_len) ^ bad_rlast);
      bus.rresp   = inj_rresp;
      bus.rid     = 4'(TB_ID);
    end
  end

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len,
                         input logic [31:0] wdat[$], input int gap_pct, input int stall_pct,
                         input logic [1:0] bresp_i, input logic [1:0] rresp_i,
                         input bit badlast_i, input bit exp_err);
    logic [31:0] got[$];
    int base, wi, cyc;
    bit hsw, got_done, stray;
    base = int'(addr >> 2); wi = 0; cyc = 0; hsw = 0; got_done = 0; stray = 0;
    if (wr) for (int i = 0; i <= len; i++) ref_mem[base + i] = wdat[i];
    cur_addr = addr; cur_len = 8'(len);
    inj_bresp = bresp_i; inj_rresp = rresp_i; bad_rlast = badlast_i;
    while (!cmd_ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_len = 8'hFF;
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    chk("awvalid_after_cmd", 32'(bus.awvalid), 32'(wr));
    chk("arvalid_after_cmd", 32'(bus.arvalid), 32'(!wr));
    cyc = 0;
    while (!got_done && cyc < 3000) begin
      if (hsw) wr_valid = 1'b0;
      if (wr && wi <= len && !wr_valid) wr_valid = ($urandom_range(0, 99) >= gap_pct);
      if (wr && wi <= len) wr_data = wdat[wi];
      rd_ready = !wr && ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      hsw = wr_valid && wr_ready;
      if (hsw) wi++;
      if (wr ? rd_valid : wr_ready) stray = 1;
      if (rd_valid && rd_ready) begin
        got.push_back(rd_data);
        chk("rd_last", 32'(rd_last), 32'(got.size() == len + 1));
      end
      if (done) begin
        got_done = 1;
        chk("err", 32'(err), 32'(exp_err));
      end
      @(posedge clk); #1; cyc++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("done_pulse", 32'(done), 32'd0);
    chk("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    chk("stray_stream", 32'(stray), 32'd0);
    if (wr) chk("wr_beats", 32'(wi), 32'(len + 1));
    else begin
      chk("rd_beats", 32'(got.size()), 32'(len + 1));
      foreach (got[i]) chk("rd_data", got[i], ref_mem[base + i]);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] q[$];
    logic [31:0] addr;
    int len, word, cyc, wi;
    bit saw_done;

    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_awvalid", 32'(bus.awvalid), 32'd0);
    chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst_bready", 32'(bus.bready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("release_cmd_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("release_cmd_ready_high", 32'(cmd_ready), 32'd1);

    q = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_cmd(1'b1, 32'h100, 3, q, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    q.delete();
    run_cmd(1'b0, 32'h100, 3, q, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h104, 0, q, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) q.push_back($urandom);
    run_cmd(1'b1, 32'h400, 15, q, 50, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    q.delete();
    run_cmd(1'b0, 32'h400, 15, q, 0, 50, 2'b00, 2'b00, 1'b0, 1'b0);

    // Error responses, then a clean command clears the sticky flag
    q = '{32'hA5A5_0001, 32'hA5A5_0002};
    run_cmd(1'b1, 32'h600, 1, q, 0, 0, 2'b10, 2'b00, 1'b0, 1'b1);
    run_cmd(1'b1, 32'h600, 1, q, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0);
    q.delete();
    run_cmd(1'b0, 32'h600, 1, q, 0, 0, 2'b00, 2'b10, 1'b0, 1'b1);
    run_cmd(1'b0, 32'h600, 1, q, 0, 0, 2'b00, 2'b00, 1'b1, 1'b1);
    run_cmd(1'b0, 32'h600, 1, q, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      len  = $urandom_range(0, 31);
      word = $urandom_range(0, 1023 - len);
      addr = 32'h1000 + 32'(word) * 4 + 32'($urandom_range(0, 3));
      q.delete();
      for (int i = 0; i <= len; i++) q.push_back($urandom);
      run_cmd(1'b1, addr, len, q, $urandom_range(0, 70), 0, 2'b00, 2'b00, 1'b0, 1'b0);
      q.delete();
      run_cmd(1'b0, addr, len, q, 0, $urandom_range(0, 70), 2'b00, 2'b00, 1'b0, 1'b0);
    end

    // Reset in the middle of an 8-beat write after two beats
    q.delete();
    for (int i = 0; i < 8; i++) begin
      q.push_back($urandom);
      ref_mem[32'h200 + i] = q[i];
    end
    cur_addr = 32'h800; cur_len = 8'd7;
    inj_bresp = 2'b00; inj_rresp = 2'b00; bad_rlast = 1'b0;
    chk("rst6_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h800; cmd_len = 8'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wi = 0; cyc = 0;
    while (wi < 2 && cyc < 200) begin
      wr_valid = 1'b1; wr_data = q[wi];
      @(negedge clk);
      if (wr_valid && wr_ready) wi++;
      @(posedge clk); #1; cyc++;
    end
    chk("rst6_two_beats", 32'(wi), 32'd2);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst6_awvalid", 32'(bus.awvalid), 32'd0);
    chk("rst6_wvalid", 32'(bus.wvalid), 32'd0);
    chk("rst6_arvalid", 32'(bus.arvalid), 32'd0);
    chk("rst6_bready", 32'(bus.bready), 32'd0);
    chk("rst6_rready", 32'(bus.rready), 32'd0);
    chk("rst6_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst6_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst6_done", 32'(done), 32'd0);
    wr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("rst6_release_low", 32'(cmd_ready), 32'd0);
    saw_done = 0;
    @(negedge clk);
    saw_done = saw_done | done;
    @(posedge clk); #1;
    chk("rst6_release_high", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("rst6_no_done", 32'(saw_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
